// File: rtl/tracker_pkg.sv
// Shared definitions for the multi-channel colour blob tracker: default
// parameters, per-channel colour window config and the result-engine states.
package tracker_pkg;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_HW      = 11;
    localparam int DEF_VW      = 10;
    localparam int DEF_CNT_W   = 20;
    localparam int DEF_MIN_PIX = 16;

    // Colour window of one channel; packed order matches cfg_data_in.
    typedef struct packed {
        logic [7:0] h_lo;
        logic [7:0] h_hi;
        logic [7:0] s_min;
        logic [7:0] v_min;
    } ch_cfg_t;

    // Reset window: only h=0 with full saturation and value can match.
    localparam ch_cfg_t CFG_RST = '{h_lo: 8'h00, h_hi: 8'h00, s_min: 8'hFF, v_min: 8'hFF};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_EMIT  = 2'd3
    } trk_state_t;

    // Hue window wraps through 0 when h_lo > h_hi, so red hues can be tracked.
    function automatic logic pix_match(input ch_cfg_t cfg, input logic [7:0] h,
                                       input logic [7:0] s, input logic [7:0] v);
        logic hue_ok;
        if (cfg.h_lo <= cfg.h_hi) begin
            hue_ok = (h >= cfg.h_lo) && (h <= cfg.h_hi);
        end else begin
            hue_ok = (h >= cfg.h_lo) || (h <= cfg.h_hi);
        end
        return hue_ok && (s >= cfg.s_min) && (v >= cfg.v_min);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider: one load cycle on start, then W iterations.
// done pulses for one cycle once the quotient is final; quotient then holds.
module seq_divider #(
    parameter int W  = 31,
    parameter int QW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic [QW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  dvs_r;
    logic [CW-1:0] cnt_r;
    logic          done_r;
    logic [W:0]    shift_s;
    logic [W:0]    diff_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shift_s = {rem_r, quo_r[W-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
    end

    // Load on start, then shift/subtract one quotient bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {W{1'b0}};
            quo_r  <= {W{1'b0}};
            dvs_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= {W{1'b0}};
            quo_r  <= dividend;
            dvs_r  <= divisor;
            cnt_r  <= CW'(W);
            done_r <= 1'b0;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r  <= cnt_r - CW'(1'b1);
            done_r <= (cnt_r == CW'(1'b1));
            if (shift_s >= {1'b0, dvs_r}) begin
                rem_r <= diff_s[W-1:0];
                quo_r <= {quo_r[W-2:0], 1'b1};
            end else begin
                rem_r <= shift_s[W-1:0];
                quo_r <= {quo_r[W-2:0], 1'b0};
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = quo_r[QW-1:0];
    assign done     = done_r;

endmodule

// File: rtl/blob_tracker_multi.sv
// Multi-channel colour blob tracker: per-channel HSV windows accumulate pixel
// count and coordinate sums over a frame; at frame end the totals are
// snapshotted and a shared divider produces centroids, emitted one channel at
// a time over a valid/ready handshake.
// Optional feature: define TRACKER_BBOX_EN for per-channel bounding boxes.
module blob_tracker_multi
    import tracker_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int HW      = DEF_HW,
    parameter int VW      = DEF_VW,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MIN_PIX = DEF_MIN_PIX
) (
    input  logic             clk,
    input  logic             rst_n_in,
    input  logic             pix_valid_in,
    input  logic [7:0]       h_in,
    input  logic [7:0]       s_in,
    input  logic [7:0]       v_in,
    input  logic [HW-1:0]    hcount_in,
    input  logic [VW-1:0]    vcount_in,
    input  logic             frame_end_in,
    input  logic             cfg_we_in,
    input  logic [2:0]       cfg_ch_in,
    input  logic [31:0]      cfg_data_in,
    input  logic [N_CH-1:0]  ch_en_in,
    output logic             res_valid_out,
    output logic [2:0]       res_ch_out,
    output logic             res_found_out,
    output logic [HW-1:0]    res_cx_out,
    output logic [VW-1:0]    res_cy_out,
    output logic [CNT_W-1:0] res_count_out,
    input  logic             res_ready_in,
    output logic             busy_out,
    output logic             overrun_out
`ifdef TRACKER_BBOX_EN
    ,
    output logic [HW-1:0]    res_xmin_out,
    output logic [HW-1:0]    res_xmax_out,
    output logic [VW-1:0]    res_ymin_out,
    output logic [VW-1:0]    res_ymax_out
`endif
);
    localparam int SUM_W = CNT_W + HW;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a);
        return (a == {CNT_W{1'b1}}) ? a : a + CNT_W'(1'b1);
    endfunction

    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
    endfunction

    ch_cfg_t          cfg_r      [N_CH];
    logic [CNT_W-1:0] acc_cnt_r  [N_CH];
    logic [SUM_W-1:0] acc_sx_r   [N_CH];
    logic [SUM_W-1:0] acc_sy_r   [N_CH];
    logic [CNT_W-1:0] snap_cnt_r [N_CH];
    logic [SUM_W-1:0] snap_sx_r  [N_CH];
    logic [SUM_W-1:0] snap_sy_r  [N_CH];
    logic [CNT_W-1:0] nxt_cnt_s  [N_CH];
    logic [SUM_W-1:0] nxt_sx_s   [N_CH];
    logic [SUM_W-1:0] nxt_sy_s   [N_CH];
    logic [N_CH-1:0]  hit_s;
`ifdef TRACKER_BBOX_EN
    logic [HW-1:0] acc_xmin_r [N_CH], acc_xmax_r [N_CH], snap_xmin_r [N_CH], snap_xmax_r [N_CH];
    logic [VW-1:0] acc_ymin_r [N_CH], acc_ymax_r [N_CH], snap_ymin_r [N_CH], snap_ymax_r [N_CH];
    logic [HW-1:0] nxt_xmin_s [N_CH], nxt_xmax_s [N_CH], cur_xmin_s, cur_xmax_s;
    logic [VW-1:0] nxt_ymin_s [N_CH], nxt_ymax_s [N_CH], cur_ymin_s, cur_ymax_s;
`endif

    trk_state_t       state_r, state_n;
    logic [2:0]       ch_r, ch_n;
    logic             wait_r, wait_n;
    logic             busy_r, valid_r, overrun_r;
    logic [CNT_W-1:0] cur_cnt_s;
    logic [SUM_W-1:0] cur_sx_s, cur_sy_s, div_num_s, div_den_s;
    logic             cur_en_s, skip_s;
    logic             div_start_s, div_done_s, cap_x_s, load_res_s;
    logic [HW-1:0]    div_quot_s, qx_r;

    // Channel config registers; writes to channels >= N_CH match no entry.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N_CH; i++) cfg_r[i] <= CFG_RST;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we_in && (cfg_ch_in == 3'(i))) cfg_r[i] <= ch_cfg_t'(cfg_data_in);
            end
        end
    end

    // Per-channel match and saturating next-accumulator values.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            hit_s[i]     = pix_valid_in && ch_en_in[i] && pix_match(cfg_r[i], h_in, s_in, v_in);
            nxt_cnt_s[i] = hit_s[i] ? sat_cnt(acc_cnt_r[i]) : acc_cnt_r[i];
            nxt_sx_s[i]  = hit_s[i] ? sat_sum(acc_sx_r[i], SUM_W'(hcount_in)) : acc_sx_r[i];
            nxt_sy_s[i]  = hit_s[i] ? sat_sum(acc_sy_r[i], SUM_W'(vcount_in)) : acc_sy_r[i];
`ifdef TRACKER_BBOX_EN
            nxt_xmin_s[i] = (hit_s[i] && (hcount_in < acc_xmin_r[i])) ? hcount_in : acc_xmin_r[i];
            nxt_xmax_s[i] = (hit_s[i] && (hcount_in > acc_xmax_r[i])) ? hcount_in : acc_xmax_r[i];
            nxt_ymin_s[i] = (hit_s[i] && (vcount_in < acc_ymin_r[i])) ? vcount_in : acc_ymin_r[i];
            nxt_ymax_s[i] = (hit_s[i] && (vcount_in > acc_ymax_r[i])) ? vcount_in : acc_ymax_r[i];
`endif
        end
    end

    // Accumulate; at frame end snapshot (including this cycle's pixel) when idle and always clear.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N_CH; i++) begin
                acc_cnt_r[i] <= {CNT_W{1'b0}}; snap_cnt_r[i] <= {CNT_W{1'b0}};
                acc_sx_r[i]  <= {SUM_W{1'b0}}; snap_sx_r[i]  <= {SUM_W{1'b0}};
                acc_sy_r[i]  <= {SUM_W{1'b0}}; snap_sy_r[i]  <= {SUM_W{1'b0}};
`ifdef TRACKER_BBOX_EN
                acc_xmin_r[i] <= {HW{1'b1}}; acc_xmax_r[i] <= {HW{1'b0}};
                acc_ymin_r[i] <= {VW{1'b1}}; acc_ymax_r[i] <= {VW{1'b0}};
                snap_xmin_r[i] <= {HW{1'b0}}; snap_xmax_r[i] <= {HW{1'b0}};
                snap_ymin_r[i] <= {VW{1'b0}}; snap_ymax_r[i] <= {VW{1'b0}};
`endif
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (frame_end_in) begin
                    if (state_r == ST_IDLE) begin
                        snap_cnt_r[i] <= nxt_cnt_s[i];
                        snap_sx_r[i]  <= nxt_sx_s[i];
                        snap_sy_r[i]  <= nxt_sy_s[i];
`ifdef TRACKER_BBOX_EN
                        snap_xmin_r[i] <= nxt_xmin_s[i]; snap_xmax_r[i] <= nxt_xmax_s[i];
                        snap_ymin_r[i] <= nxt_ymin_s[i]; snap_ymax_r[i] <= nxt_ymax_s[i];
`endif
                    end
                    acc_cnt_r[i] <= {CNT_W{1'b0}};
                    acc_sx_r[i]  <= {SUM_W{1'b0}};
                    acc_sy_r[i]  <= {SUM_W{1'b0}};
`ifdef TRACKER_BBOX_EN
                    acc_xmin_r[i] <= {HW{1'b1}}; acc_xmax_r[i] <= {HW{1'b0}};
                    acc_ymin_r[i] <= {VW{1'b1}}; acc_ymax_r[i] <= {VW{1'b0}};
`endif
                end else begin
                    acc_cnt_r[i] <= nxt_cnt_s[i];
                    acc_sx_r[i]  <= nxt_sx_s[i];
                    acc_sy_r[i]  <= nxt_sy_s[i];
`ifdef TRACKER_BBOX_EN
                    acc_xmin_r[i] <= nxt_xmin_s[i]; acc_xmax_r[i] <= nxt_xmax_s[i];
                    acc_ymin_r[i] <= nxt_ymin_s[i]; acc_ymax_r[i] <= nxt_ymax_s[i];
`endif
                end
            end
        end
    end

    // Select the snapshot of the channel currently being processed.
    always_comb begin
        cur_cnt_s = {CNT_W{1'b0}};
        cur_sx_s  = {SUM_W{1'b0}};
        cur_sy_s  = {SUM_W{1'b0}};
        cur_en_s  = 1'b0;
`ifdef TRACKER_BBOX_EN
        cur_xmin_s = {HW{1'b0}}; cur_xmax_s = {HW{1'b0}};
        cur_ymin_s = {VW{1'b0}}; cur_ymax_s = {VW{1'b0}};
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (ch_r == 3'(i)) begin
                cur_cnt_s = snap_cnt_r[i];
                cur_sx_s  = snap_sx_r[i];
                cur_sy_s  = snap_sy_r[i];
                cur_en_s  = ch_en_in[i];
`ifdef TRACKER_BBOX_EN
                cur_xmin_s = snap_xmin_r[i]; cur_xmax_s = snap_xmax_r[i];
                cur_ymin_s = snap_ymin_r[i]; cur_ymax_s = snap_ymax_r[i];
`endif
            end
        end
        // A zero count is always skipped so the divider never sees a zero divisor.
        skip_s = !cur_en_s || (cur_cnt_s < CNT_W'(MIN_PIX)) || (cur_cnt_s == {CNT_W{1'b0}});
    end

    // Result engine next-state logic and divider control.
    always_comb begin
        state_n     = state_r;
        ch_n        = ch_r;
        wait_n      = wait_r;
        div_start_s = 1'b0;
        cap_x_s     = 1'b0;
        load_res_s  = 1'b0;
        div_num_s   = (state_r == ST_DIV_Y) ? cur_sy_s : cur_sx_s;
        div_den_s   = SUM_W'(cur_cnt_s);
        case (state_r)
            ST_IDLE: begin
                if (frame_end_in) begin
                    state_n = ST_DIV_X;
                    ch_n    = 3'd0;
                    wait_n  = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DIV_X: begin
                if (!wait_r) begin
                    if (skip_s) begin
                        state_n    = ST_EMIT;
                        load_res_s = 1'b1;
                    end else begin
                        div_start_s = 1'b1;
                        wait_n      = 1'b1;
                    end
                end else if (div_done_s) begin
                    cap_x_s = 1'b1;
                    state_n = ST_DIV_Y;
                    wait_n  = 1'b0;
                end else begin
                    state_n = ST_DIV_X;
                end
            end
            ST_DIV_Y: begin
                if (!wait_r) begin
                    div_start_s = 1'b1;
                    wait_n      = 1'b1;
                end else if (div_done_s) begin
                    state_n    = ST_EMIT;
                    load_res_s = 1'b1;
                    wait_n     = 1'b0;
                end else begin
                    state_n = ST_DIV_Y;
                end
            end
            ST_EMIT: begin
                if (res_ready_in) begin
                    wait_n = 1'b0;
                    if (ch_r == 3'(N_CH - 1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DIV_X;
                        ch_n    = ch_r + 3'd1;
                    end
                end else begin
                    state_n = ST_EMIT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state plus registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= ST_IDLE;
            ch_r      <= 3'd0;
            wait_r    <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            ch_r      <= ch_n;
            wait_r    <= wait_n;
            busy_r    <= (state_n != ST_IDLE);
            valid_r   <= (state_n == ST_EMIT);
            overrun_r <= overrun_r | (frame_end_in && (state_r != ST_IDLE));
        end
    end

    // Capture the x quotient and load the result fields on entry to EMIT.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            qx_r          <= {HW{1'b0}};
            res_ch_out    <= 3'd0;
            res_found_out <= 1'b0;
            res_cx_out    <= {HW{1'b0}};
            res_cy_out    <= {VW{1'b0}};
            res_count_out <= {CNT_W{1'b0}};
`ifdef TRACKER_BBOX_EN
            res_xmin_out <= {HW{1'b0}}; res_xmax_out <= {HW{1'b0}};
            res_ymin_out <= {VW{1'b0}}; res_ymax_out <= {VW{1'b0}};
`endif
        end else begin
            if (cap_x_s) qx_r <= div_quot_s;
            if (load_res_s) begin
                res_ch_out    <= ch_r;
                res_found_out <= !skip_s;
                res_cx_out    <= skip_s ? {HW{1'b0}} : qx_r;
                res_cy_out    <= skip_s ? {VW{1'b0}} : div_quot_s[VW-1:0];
                res_count_out <= cur_cnt_s;
`ifdef TRACKER_BBOX_EN
                res_xmin_out <= skip_s ? {HW{1'b0}} : cur_xmin_s;
                res_xmax_out <= skip_s ? {HW{1'b0}} : cur_xmax_s;
                res_ymin_out <= skip_s ? {VW{1'b0}} : cur_ymin_s;
                res_ymax_out <= skip_s ? {VW{1'b0}} : cur_ymax_s;
`endif
            end
        end
    end

    seq_divider #(.W(SUM_W), .QW(HW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n_in),
        .start    (div_start_s),
        .dividend (div_num_s),
        .divisor  (div_den_s),
        .quotient (div_quot_s),
        .done     (div_done_s)
    );

    assign res_valid_out = valid_r;
    assign busy_out      = busy_r;
    assign overrun_out   = overrun_r;

endmodule

// File: tb/tb_blob_tracker_multi.sv
// Directed bench for blob_tracker_multi with default parameters.
module tb_blob_tracker_multi;
    localparam int HW = 11, VW = 10, CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst_n_in;
    logic             pix_valid_in, frame_end_in, cfg_we_in, res_ready_in;
    logic [7:0]       h_in, s_in, v_in;
    logic [HW-1:0]    hcount_in;
    logic [VW-1:0]    vcount_in;
    logic [2:0]       cfg_ch_in;
    logic [31:0]      cfg_data_in;
    logic [3:0]       ch_en_in;
    logic             res_valid_out, res_found_out, busy_out, overrun_out;
    logic [2:0]       res_ch_out;
    logic [HW-1:0]    res_cx_out;
    logic [VW-1:0]    res_cy_out;
    logic [CNT_W-1:0] res_count_out;
`ifdef TRACKER_BBOX_EN
    logic [HW-1:0]    res_xmin_out, res_xmax_out;
    logic [VW-1:0]    res_ymin_out, res_ymax_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 clk = ~clk;

    blob_tracker_multi dut (
        .clk(clk), .rst_n_in(rst_n_in), .pix_valid_in(pix_valid_in),
        .h_in(h_in), .s_in(s_in), .v_in(v_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .frame_end_in(frame_end_in),
        .cfg_we_in(cfg_we_in), .cfg_ch_in(cfg_ch_in), .cfg_data_in(cfg_data_in),
        .ch_en_in(ch_en_in), .res_valid_out(res_valid_out), .res_ch_out(res_ch_out),
        .res_found_out(res_found_out), .res_cx_out(res_cx_out), .res_cy_out(res_cy_out),
        .res_count_out(res_count_out), .res_ready_in(res_ready_in),
        .busy_out(busy_out), .overrun_out(overrun_out)
`ifdef TRACKER_BBOX_EN
        , .res_xmin_out(res_xmin_out), .res_xmax_out(res_xmax_out),
        .res_ymin_out(res_ymin_out), .res_ymax_out(res_ymax_out)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic cfg_write(input logic [2:0] ch, input logic [31:0] d);
        cfg_we_in = 1'b1; cfg_ch_in = ch; cfg_data_in = d;
        @(negedge clk);
        cfg_we_in = 1'b0;
    endtask

    task automatic pix(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                       input int x, input int y, input int n, input bit fe_last);
        for (int i = 0; i < n; i++) begin
            pix_valid_in = 1'b1; h_in = h; s_in = s; v_in = v;
            hcount_in = HW'(x); vcount_in = VW'(y);
            frame_end_in = fe_last && (i == n - 1);
            @(negedge clk);
        end
        pix_valid_in = 1'b0; frame_end_in = 1'b0;
    endtask

    task automatic frame_end();
        frame_end_in = 1'b1;
        @(negedge clk);
        frame_end_in = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, optionally stall ready, then accept it.
    task automatic get_result(input int ch, input int found, input int cx, input int cy,
                              input int cnt, input int hold, output int wait_cycles);
        logic [63:0] exp_fields;
        exp_fields = {22'd0, 3'(ch), 1'(found), 11'(cx), 10'(cy), 20'(cnt)};
        wait_cycles = 0;
        while (!res_valid_out && wait_cycles < 400) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!res_valid_out) begin
            check_val($sformatf("ch%0d_valid_timeout", ch), 64'(res_valid_out), 64'd1);
        end else begin
            check_val($sformatf("ch%0d_ch", ch),    64'(res_ch_out),    64'(ch));
            check_val($sformatf("ch%0d_found", ch), 64'(res_found_out), 64'(found));
            check_val($sformatf("ch%0d_cx", ch),    64'(res_cx_out),    64'(cx));
            check_val($sformatf("ch%0d_cy", ch),    64'(res_cy_out),    64'(cy));
            check_val($sformatf("ch%0d_count", ch), 64'(res_count_out), 64'(cnt));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_val("hold_valid", 64'(res_valid_out), 64'd1);
                check_val("hold_fields", {22'd0, res_ch_out, res_found_out, res_cx_out,
                                          res_cy_out, res_count_out}, exp_fields);
            end
            res_ready_in = 1'b1;
            @(negedge clk);
            res_ready_in = 1'b0;
        end
    endtask

    initial begin
        rst_n_in = 1'b0; pix_valid_in = 1'b0; frame_end_in = 1'b0; cfg_we_in = 1'b0;
        res_ready_in = 1'b0; h_in = 8'd0; s_in = 8'd0; v_in = 8'd0;
        hcount_in = '0; vcount_in = '0; cfg_ch_in = 3'd0; cfg_data_in = 32'd0; ch_en_in = 4'hF;
        repeat (3) @(negedge clk);
        check_val("rst_valid",   64'(res_valid_out), 64'd0);
        check_val("rst_busy",    64'(busy_out),      64'd0);
        check_val("rst_overrun", 64'(overrun_out),   64'd0);
        check_val("rst_fields",  {res_ch_out, res_found_out, res_cx_out, res_cy_out, res_count_out}, 64'd0);
        rst_n_in = 1'b1;
        @(negedge clk);

        cfg_write(3'd0, 32'h10204040);
        cfg_write(3'd1, 32'hF0050000);
        cfg_write(3'd2, 32'h50601010);
        cfg_write(3'd4, 32'h00FF0000);   // out-of-range channel, must be ignored

        // Frame 1: hue wrap on ch1, below-threshold ch2, last ch0 pixel rides on frame_end.
        pix(8'h80, 8'h80, 8'h80, 5, 5, 1, 1'b0);
        pix(8'hF8, 8'h80, 8'h80, 10, 20, 10, 1'b0);
        pix(8'h02, 8'h80, 8'h80, 30, 40, 10, 1'b0);
        pix(8'h55, 8'h20, 8'h20, 7, 7, 10, 1'b0);
        pix(8'h18, 8'h80, 8'h80, 200, 100, 99, 1'b0);
        pix(8'h18, 8'h80, 8'h80, 200, 100, 1, 1'b1);
        check_val("f1_busy", 64'(busy_out), 64'd1);
        get_result(0, 1, 200, 100, 100, 0, lat);
        check_val("f1_ch0_div_latency", 64'(lat >= 64), 64'd1);
        get_result(1, 1, 20, 30, 20, 0, lat);
        get_result(2, 0, 0, 0, 10, 0, lat);
        check_val("f1_ch2_skip_latency", 64'(lat <= 3), 64'd1);
        get_result(3, 0, 0, 0, 0, 0, lat);
        @(negedge clk);
        check_val("f1_idle_busy", 64'(busy_out), 64'd0);
        check_val("f1_overrun", 64'(overrun_out), 64'd0);

        // Frame 2: second frame_end lands in ch0's y division.
        pix(8'h18, 8'h80, 8'h80, 50, 60, 20, 1'b0);
        frame_end();
        repeat (4) @(negedge clk);
        pix(8'h18, 8'h80, 8'h80, 999, 500, 30, 1'b0);
        repeat (10) @(negedge clk);
        frame_end();
        check_val("f2_overrun", 64'(overrun_out), 64'd1);
        check_val("f2_busy", 64'(busy_out), 64'd1);
        get_result(0, 1, 50, 60, 20, 50, lat);
        get_result(1, 0, 0, 0, 0, 0, lat);
        get_result(2, 0, 0, 0, 0, 0, lat);
        get_result(3, 0, 0, 0, 0, 0, lat);

        // Frame 3: accumulators restarted from zero; overrun stays sticky.
        pix(8'h18, 8'h80, 8'h80, 300, 200, 17, 1'b1);
        get_result(0, 1, 300, 200, 17, 0, lat);
        get_result(1, 0, 0, 0, 0, 0, lat);
        get_result(2, 0, 0, 0, 0, 0, lat);
        get_result(3, 0, 0, 0, 0, 0, lat);
        check_val("f3_overrun_sticky", 64'(overrun_out), 64'd1);

        // Reset pulsed during ch0's x division.
        pix(8'h18, 8'h80, 8'h80, 1, 1, 20, 1'b1);
        repeat (10) @(negedge clk);
        check_val("pre_rst_busy", 64'(busy_out), 64'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check_val("mid_rst_busy",    64'(busy_out),      64'd0);
        check_val("mid_rst_valid",   64'(res_valid_out), 64'd0);
        check_val("mid_rst_overrun", 64'(overrun_out),   64'd0);
        check_val("mid_rst_fields",  {res_ch_out, res_found_out, res_cx_out, res_cy_out, res_count_out}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_rst_busy", 64'(busy_out), 64'd0);

        // Reset-default windows match h=0,s=v=0xFF; ch0 disabled.
        ch_en_in = 4'b1110;
        pix(8'h00, 8'hFF, 8'hFF, 4, 4, 20, 1'b1);
        get_result(0, 0, 0, 0, 0, 0, lat);
        get_result(1, 1, 4, 4, 20, 0, lat);
        get_result(2, 1, 4, 4, 20, 0, lat);
        get_result(3, 1, 4, 4, 20, 0, lat);
        @(negedge clk);
        check_val("end_busy", 64'(busy_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
